// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Load/store controller for the MEM stage of the 16-bit MIPS pipeline. It
// takes one request at a time from the pipeline and drives a word-wide data
// memory that has no byte enables. Byte stores are done as read-modify-write.
// Load results are formatted as a word, or as a byte that is sign- or
// zero-extended.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   req_valid      request present
//   req_ready      unit can accept a request (state is IDLE)
//   req_we         1 = store, 0 = load
//   req_byte       1 = byte access, 0 = word access
//   req_signed     byte loads: 1 = sign-extend, 0 = zero-extend
//   req_addr       byte address
//   req_wdata      store data; byte stores use [7:0]
//   resp_valid     one-cycle completion pulse
//   resp_err       qualifies resp_valid: misaligned word access
//   resp_data      last successful load result (held)
//   mem_rd_en      data memory read strobe (1-cycle read latency)
//   mem_wr_en      data memory write strobe
//   mem_addr       data memory address (latched request address)
//   mem_wr_data    data memory write data
//   mem_read_data  data memory read data, valid the cycle after mem_rd_en
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_byte,
    input  logic                 req_signed,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [BUS_WIDTH-1:0] resp_data,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wr_data,
    input  logic [BUS_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LD_DONE,
        RMW_WR,
        WR
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields captured on accept and used for the rest of the operation.
    logic                 we_q;
    logic                 byte_q;
    logic                 signed_q;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;

    logic                 accept;
    logic                 misaligned;
    logic                 resp_valid_next;
    logic                 resp_err_next;
    logic [7:0]           rd_lane;
    logic [BUS_WIDTH-1:0] load_fmt;
    logic [BUS_WIDTH-1:0] rmw_data;

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    // Only word accesses can be misaligned; bytes are legal at any address.
    assign misaligned = !req_byte && req_addr[0];
    assign mem_addr   = addr_q;

    // Lane selection is little-endian: addr[0]=0 picks [7:0], addr[0]=1 picks [15:8].
    assign rd_lane  = addr_q[0] ? mem_read_data[15:8] : mem_read_data[7:0];
    assign load_fmt = !byte_q   ? mem_read_data
                    : signed_q  ? {{8{rd_lane[7]}}, rd_lane}
                    :             {8'h00, rd_lane};
    // Merge is taken straight from the read data returned for the RD cycle.
    assign rmw_data = addr_q[0] ? {wdata_q[7:0], mem_read_data[7:0]}
                                : {mem_read_data[15:8], wdata_q[7:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_next;
            resp_valid <= resp_valid_next;
            resp_err   <= resp_err_next;
            if (accept) begin
                we_q     <= req_we;
                byte_q   <= req_byte;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            // Stores and errors leave the held load result untouched.
            if (state == LD_DONE) begin
                resp_data <= load_fmt;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        mem_rd_en       = 1'b0;
        mem_wr_en       = 1'b0;
        mem_wr_data     = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        // Rejected without touching memory; stay ready.
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                    end else if (!req_we || req_byte) begin
                        // Loads and byte stores both need the current word first.
                        state_next = RD;
                    end else begin
                        state_next = WR;
                    end
                end
            end
            RD: begin
                mem_rd_en  = 1'b1;
                state_next = we_q ? RMW_WR : LD_DONE;
            end
            LD_DONE: begin
                resp_valid_next = 1'b1;
                state_next      = IDLE;
            end
            RMW_WR: begin
                mem_wr_en       = 1'b1;
                mem_wr_data     = rmw_data;
                resp_valid_next = 1'b1;
                state_next      = IDLE;
            end
            WR: begin
                mem_wr_en       = 1'b1;
                mem_wr_data     = wdata_q;
                resp_valid_next = 1'b1;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Strobes are suppressed during reset so an abandoned operation
        // cannot touch memory in the reset cycle.
        if (rst) begin
            mem_rd_en   = 1'b0;
            mem_wr_en   = 1'b0;
            mem_wr_data = '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Drives mem_access_unit against a behavioural word memory. Each issued
// request is run through a reference model (a plain word array plus the last
// load result) and the expected response is queued. A monitor on the falling
// edge pops and compares response data, error flag, latency and the cycles in
// which the read/write strobes appeared.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [15:0] resp_data;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_read_data = '0;

    mem_access_unit #(.BUS_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_byte      (req_byte),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_err      (resp_err),
        .resp_data     (resp_data),
        .mem_rd_en     (mem_rd_en),
        .mem_wr_en     (mem_wr_en),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_read_data (mem_read_data)
    );

    always #5 clk = ~clk;

    // Word-addressed data memory, registered read, write at the edge.
    logic [15:0] mem [0:32767] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[15:1]] <= mem_wr_data;
        if (mem_rd_en) mem_read_data <= mem[mem_addr[15:1]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        err;
        logic [15:0] data;
        int          acc;     // accept cycle
        int          lat;     // response cycle offset
        int          rd_off;  // read strobe cycle offset, -1 = none
        int          wr_off;  // write strobe cycle offset, -1 = none
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [0:32767] = '{default: 16'h0000};
    logic [15:0] last_data = 16'h0000;

    function automatic exp_t model(input logic we, input logic byt, input logic sgn,
                                   input logic [15:0] addr, input logic [15:0] wdata);
        exp_t        e;
        int          widx;
        int          lane_val;
        int          word_val;
        widx     = int'(addr) / 2;
        word_val = int'(ref_mem[widx]);
        e.err    = 1'b0;
        e.acc    = 0;
        if (!byt && (addr % 2 == 1)) begin
            e.err = 1'b1; e.lat = 1; e.rd_off = -1; e.wr_off = -1;
        end else if (we && !byt) begin
            ref_mem[widx] = wdata;
            e.lat = 2; e.rd_off = -1; e.wr_off = 1;
        end else if (we) begin
            // Replace one byte of the word, keep the other.
            if (addr % 2 == 1) word_val = (word_val % 256) + int'(wdata % 256) * 256;
            else               word_val = (word_val / 256) * 256 + int'(wdata % 256);
            ref_mem[widx] = 16'(word_val);
            e.lat = 3; e.rd_off = 1; e.wr_off = 2;
        end else begin
            if (byt) begin
                lane_val = (addr % 2 == 1) ? word_val / 256 : word_val % 256;
                if (sgn && lane_val >= 128) last_data = 16'(lane_val + 32'hFF00);
                else                        last_data = 16'(lane_val);
            end else begin
                last_data = 16'(word_val);
            end
            e.lat = 3; e.rd_off = 1; e.wr_off = -1;
        end
        e.data = last_data;
        return e;
    endfunction

    // ---------------- monitor ----------------
    int rd_log[$];
    int wr_log[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mem_rd_en && mem_wr_en) check("strobe_exclusive", 1, 0);
            if (mem_rd_en) rd_log.push_back(cyc);
            if (mem_wr_en) wr_log.push_back(cyc);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_err", resp_err, e.err);
                    check("resp_data", resp_data, e.data);
                    check("resp_latency", cyc - e.acc, e.lat);
                    check("rd_strobe_count", rd_log.size(), (e.rd_off >= 0) ? 1 : 0);
                    if (rd_log.size() == 1 && e.rd_off >= 0)
                        check("rd_strobe_cycle", rd_log[0] - e.acc, e.rd_off);
                    check("wr_strobe_count", wr_log.size(), (e.wr_off >= 0) ? 1 : 0);
                    if (wr_log.size() == 1 && e.wr_off >= 0)
                        check("wr_strobe_cycle", wr_log[0] - e.acc, e.wr_off);
                end
                rd_log.delete();
                wr_log.delete();
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input logic we, input logic byt, input logic sgn,
                         input logic [15:0] addr, input logic [15:0] wdata);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_byte   = byt;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        e     = model(we, byt, sgn, addr, wdata);
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        #3;
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},   req_ready,   1);
        check({tag, "_resp_valid"},  resp_valid,  0);
        check({tag, "_resp_err"},    resp_err,    0);
        check({tag, "_resp_data"},   resp_data,   0);
        check({tag, "_mem_addr"},    mem_addr,    0);
        check({tag, "_mem_rd_en"},   mem_rd_en,   0);
        check({tag, "_mem_wr_en"},   mem_wr_en,   0);
        check({tag, "_mem_wr_data"}, mem_wr_data, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Word store then word load (load accepted in the store's response cycle).
        issue(1, 0, 0, 16'h0010, 16'hBEEF);
        issue(0, 0, 0, 16'h0010, 16'h0000);
        drain();
        check("plan_word_load", resp_data, 16'hBEEF);

        // Byte read-modify-write into both lanes.
        issue(1, 0, 0, 16'h0020, 16'h1234);
        issue(1, 1, 0, 16'h0021, 16'h00AB);
        issue(0, 0, 0, 16'h0020, 16'h0000);
        drain();
        check("plan_rmw_hi", resp_data, 16'hAB34);
        issue(1, 1, 0, 16'h0020, 16'h77CD);
        issue(0, 0, 0, 16'h0020, 16'h0000);
        drain();
        check("plan_rmw_lo", resp_data, 16'hABCD);

        // Byte loads, signed and unsigned, both lanes.
        issue(1, 0, 0, 16'h0030, 16'h80F0);
        issue(0, 1, 1, 16'h0030, 16'h0000);
        drain();
        check("plan_sload_lo", resp_data, 16'hFFF0);
        issue(0, 1, 0, 16'h0030, 16'h0000);
        drain();
        check("plan_uload_lo", resp_data, 16'h00F0);
        issue(0, 1, 1, 16'h0031, 16'h0000);
        drain();
        check("plan_sload_hi", resp_data, 16'hFF80);
        issue(0, 1, 0, 16'h0031, 16'h0000);
        drain();
        check("plan_uload_hi", resp_data, 16'h0080);

        // Misaligned word load and store: error, no strobes, data held.
        issue(0, 0, 0, 16'h0041, 16'h0000);
        issue(1, 0, 0, 16'h0043, 16'hDEAD);
        drain();
        check("plan_misaligned_hold", resp_data, 16'h0080);

        // Reset while a byte store sits in RMW_WR: no write may land.
        issue(1, 0, 0, 16'h0050, 16'h5555);
        drain();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 16'h0050; req_wdata = 16'h00AA;
        #1 check("rmw_abort_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1 check("rmw_abort_rd_phase", mem_rd_en, 1);
        @(negedge clk);
        #1 check("rmw_abort_wr_phase", mem_wr_en, 1);
        rst = 1'b1;
        #1 check("rmw_abort_wr_gated", mem_wr_en, 0);
        @(posedge clk);
        #1 check_reset_outputs("rmw_abort");
        @(negedge clk);
        rst = 1'b0;
        rd_log.delete();
        wr_log.delete();
        last_data = 16'h0000;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("post_reset_idle");
        issue(0, 0, 0, 16'h0050, 16'h0000);
        drain();
        check("plan_rmw_abort_load", resp_data, 16'h5555);

        // Randomised mix over a small address window, with and without gaps.
        for (int i = 0; i < 400; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)),
                  16'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();

        // Read back every word of the random window.
        for (int a = 0; a < 64; a += 2) begin
            issue(0, 0, 0, 16'(a), 16'h0000);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store controller for the MEM stage of the 16-bit MIPS pipeline. It sits directly upstream of the data memory. It accepts one load or store request at a time from the pipeline and drives the memory's rd_en/wr_en/addr/wr_data strobes. It returns formatted load data (byte or word, sign- or zero-extended). Byte stores are implemented as read-modify-write, because the memory is word-wide and has no byte enables.

## Interface
- BUS_WIDTH, 16, address/data width; the logic is defined for 16 only.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; equals (state==IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_signed  in  1  byte loads: 1 = sign-extend, 0 = zero-extend; ignored otherwise.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; byte stores use bits [7:0].
- resp_valid  out  1  one-cycle pulse: operation complete.
- resp_err  out  1  qualifies resp_valid: misaligned word access.
- resp_data  out  16  load result; holds value until next successful load.
- mem_rd_en  out  1  to data memory rd_en.
- mem_wr_en  out  1  to data memory wr_en.
- mem_addr  out  16  to data memory addr; equals the latched request address.
- mem_wr_data  out  16  to data memory wr_data.
- mem_read_data  in  16  from data memory; valid the cycle after mem_rd_en.

## Operation
- The data memory is word-addressed by addr[15:1]. Reads are registered with 1-cycle latency. Writes commit at the clock edge of a cycle with wr_en high.
- Byte lanes are little-endian: addr[0]=0 selects bits [7:0]; addr[0]=1 selects bits [15:8].
- On accept (req_valid & req_ready), the unit latches we/byte/signed/addr/wdata.
- FSM states are IDLE, RD, LD_DONE, RMW_WR and WR.
  - IDLE, word access with addr[0]=1: no memory access. Next cycle resp_valid=1, resp_err=1. State remains IDLE.
  - IDLE, load accepted: go to RD.
  - IDLE, word store accepted: go to WR.
  - IDLE, byte store accepted: go to RD.
  - RD: mem_rd_en=1. Next state is LD_DONE for a load, RMW_WR for a byte store.
  - LD_DONE: at the edge, resp_data <= formatted mem_read_data and resp_valid <= 1. Go to IDLE.
    - Word load: raw data.
    - Byte load: selected lane in [7:0]; [15:8] is either the sign copy of bit 7 of the lane (req_signed=1) or zeros (req_signed=0).
  - RMW_WR: mem_wr_en=1. mem_wr_data = mem_read_data with the selected lane replaced by wdata[7:0]; the other lane is unchanged. Merge is combinational from mem_read_data. At the edge, resp_valid <= 1. Go to IDLE.
  - WR: mem_wr_en=1, mem_wr_data = wdata. At the edge, resp_valid <= 1. Go to IDLE.
- mem_rd_en and mem_wr_en are decoded from state and gated with !rst. They are never both high.
- Stores and errors leave resp_data unchanged. resp_err=0 on every successful completion.

## Timing
- Cycle numbering: cycle 0 is the accept cycle. resp_valid is visible in the cycle given below.
  - Misaligned access: cycle 1.
  - Word store: cycle 2. Memory write commits at the end of cycle 1.
  - Load: cycle 3. mem_rd_en is high in cycle 1; data is sampled at the end of cycle 2.
  - Byte store: cycle 3. Write commits at the end of cycle 2.
- req_ready is high in the resp_valid cycle, so back-to-back requests are allowed. A new request may be accepted in the same cycle a previous response is presented.
- resp_valid is a single-cycle pulse and is never held.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_data=0, mem_addr=0, mem_rd_en=0, mem_wr_en=0, mem_wr_data=0.
- Reset mid-operation: the operation is abandoned. No strobe is asserted during the reset cycle or afterwards, and no resp_valid is produced. A byte store aborted in RMW_WR does not write.
- req_valid while busy is ignored; the requester holds it until req_ready.

## Test plan
- Word store 0xBEEF to addr 0x0010, then word load from 0x0010 -> mem_wr_en high exactly cycle 1; load resp_valid in cycle 3 with resp_data=0xBEEF, resp_err=0.
- Word 0x1234 at 0x0020. Byte store 0xAB to 0x0021, then word load 0x0020 -> resp_data=0xAB34. Then byte store 0xCD to 0x0020, then word load -> resp_data=0xABCD.
- Word 0x80F0 at 0x0030.
  - Signed byte load 0x0030 -> resp_data=0xFFF0.
  - Unsigned byte load 0x0030 -> resp_data=0x00F0.
  - Signed byte load 0x0031 -> resp_data=0xFF80.
  - Unsigned byte load 0x0031 -> resp_data=0x0080.
- Word load from 0x0041 -> resp_valid=1, resp_err=1 in cycle 1; mem_rd_en and mem_wr_en stay 0; resp_data is unchanged.
- Back-to-back: a load issued in the cycle of a store's resp_valid -> accepted in that same cycle, with correct data 3 cycles later.
- rst asserted while in RMW_WR of a byte store to 0x0050 (word 0x5555) -> no write; a later load of 0x0050 returns 0x5555; all outputs are at their reset values after reset.
